multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS datapath: one shared memory, IR, ALU and ALUOut.
- Takes the latched IR word and a memory ready handshake.
- Drives all datapath enables and mux selects, and keeps cycle and retired-instruction counters.
- Replaces the single-cycle combinational control as the core's instruction sequencer.

Parameters:
- CNT_W, 32, width of cycle_count and instr_count.
- HALT_ON_ZERO, 1, when 1 an IR word of 32'h00000000 in DECODE enters HALT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr  input  32  IR contents; opcode = instr[31:26].
- mem_ready  input  1  memory completes the access this cycle.
- pcwrite  output  1  unconditional PC load.
- pcwritecond  output  1  PC load if the branch condition holds.
- branch_ne  output  1  branch condition is !Zero (BNE); otherwise Zero.
- iord  output  1  memory address mux: 0 = PC, 1 = ALUOut.
- memread  output  1  memory read request.
- memwrite  output  1  memory write request.
- irwrite  output  1  IR load.
- memtoreg  output  2  write-back data: 00 ALUOut, 01 MDR, 10 PC.
- regdst  output  2  destination register: 00 rt, 01 rd, 10 $31.
- regwrite  output  1  register file write.
- alusrca  output  1  ALU A: 0 = PC, 1 = rs.
- alusrcb  output  2  ALU B: 00 rt, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm << 2.
- aluop  output  2  00 add, 01 sub, 10 funct-decoded.
- pcsource  output  2  PC source: 00 ALU, 01 ALUOut, 10 jump address.
- halted  output  1  FSM is in HALT.
- illegal  output  1  HALT was entered on an unknown opcode.
- state  output  4  current state, for debug.
- cycle_count  output  CNT_W  cycles spent outside HALT.
- instr_count  output  CNT_W  instructions retired.

Behaviour:
- Supported opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, JAL 000011, ADDI 001000.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, BRANCH 8, JUMP 9, JAL 10, ADDIEX 11, ADDIWB 12, HALT 13.
- Every output not listed for a state is 0.
- FETCH: memread=1, alusrcb=01, aluop=00, pcsource=00; pcwrite=irwrite=mem_ready. Holds until mem_ready=1, then goes to DECODE.
- DECODE: alusrcb=11, aluop=00 (branch target into ALUOut).
  - word 0 with HALT_ON_ZERO=1 -> HALT.
  - LW/SW -> MEMADR; R-type -> RTEXEC; BEQ/BNE -> BRANCH; J -> JUMP; JAL -> JAL; ADDI -> ADDIEX.
  - any other opcode -> HALT with illegal set.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: memread=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: regwrite=1, regdst=00, memtoreg=01. -> FETCH.
- MEMWR: memwrite=1, iord=1. Holds until mem_ready, then FETCH.
- RTEXEC: alusrca=1, alusrcb=00, aluop=10. -> RTWB.
- RTWB: regwrite=1, regdst=01, memtoreg=00. -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, branch_ne=(opcode==BNE). -> FETCH.
- JUMP: pcwrite=1, pcsource=10. -> FETCH.
- JAL: pcwrite=1, pcsource=10, regwrite=1, regdst=10, memtoreg=10. The PC still holds PC+4, so it is the link value. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. -> ADDIWB.
- ADDIWB: regwrite=1, regdst=00, memtoreg=00. -> FETCH.
- HALT: absorbing until reset; halted=1; all strobes 0.
- Handshake:
  - mem_ready is sampled only in FETCH, MEMRD and MEMWR, and ignored elsewhere.
  - During a stall, memread/memwrite/iord stay asserted and stable.
  - mem_ready held high gives zero-wait operation.
- CPI with zero wait: LW 5; SW, R-type, ADDI 4; BEQ, BNE, J, JAL 3.
- Counters:
  - cycle_count increments on every clock edge while state != HALT.
  - instr_count increments on every transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^CNT_W.
- Reset (asynchronous, any time, including mid-stall): state=FETCH, counters=0, illegal=0, halted=0.
  - While reset is high, pcwrite, irwrite, regwrite and memwrite are forced to 0; memread=1.
- illegal stays 1 until reset.

Test Plan:
- Reset then LW (instr=8C080004), mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 with memtoreg=01 only in state 4; instr_count=1, cycle_count=5.
- FETCH with mem_ready low for 3 cycles, then high -> state stays 0 for 4 cycles; memread=1 throughout; pcwrite/irwrite pulse exactly once, on the ready cycle.
- BNE (instr=1509FFFF) -> state 8 with pcwritecond=1, branch_ne=1, aluop=01. BEQ (11090003) -> branch_ne=0. Both return to 0 after 3 cycles.
- JAL (0C100004) -> state 10 with pcwrite=1, pcsource=10, regdst=10, memtoreg=10, regwrite=1.
- Opcode 111111 -> HALT, halted=1, illegal=1; instr=00000000 -> HALT, illegal=0. In both cases cycle_count freezes.
- Reset asserted during a MEMWR stall -> state=0 immediately (asynchronously) and counters=0; memwrite never asserts after reset is sampled.

Source files
------------

// File: rtl/multicycle_control.sv
// Control sequencer for a multi-cycle MIPS datapath: walks each instruction through
// fetch/decode/execute/memory/write-back states and drives the datapath strobes and selects.
module multicycle_control #(
  parameter int unsigned CNT_W        = 32,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             branch_ne,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic [1:0]       memtoreg,
  output logic [1:0]       regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_JAL    = 4'd10, S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12, S_HALT   = 4'd13
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] opcode;
  logic       zero_halt;
  logic       decode_bad;

  logic       pcwrite_d, pcwrite_q, pcwritecond_d, branch_ne_d, iord_d;
  logic       memread_d, memwrite_d, regwrite_d, alusrca_d, halted_d;
  logic [1:0] memtoreg_d, regdst_d, alusrcb_d, aluop_d, pcsource_d;

  assign opcode    = instr[31:26];
  assign zero_halt = HALT_ON_ZERO && (instr == 32'h0000_0000);

  // Next-state logic; mem_ready only matters in the three memory-access states.
  always_comb begin
    state_d    = state_q;
    decode_bad = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (zero_halt) state_d = S_HALT;
        else begin
          case (opcode)
            OP_LW, OP_SW:   state_d = S_MEMADR;
            OP_RTYPE:       state_d = S_RTEXEC;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            OP_JAL:         state_d = S_JAL;
            OP_ADDI:        state_d = S_ADDIEX;
            default: begin
              state_d    = S_HALT;
              decode_bad = 1'b1;
            end
          endcase
        end
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTEXEC: state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_JAL:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    pcwrite_d     = 1'b0;
    pcwritecond_d = 1'b0;
    branch_ne_d   = 1'b0;
    iord_d        = 1'b0;
    memread_d     = 1'b0;
    memwrite_d    = 1'b0;
    regwrite_d    = 1'b0;
    alusrca_d     = 1'b0;
    halted_d      = 1'b0;
    memtoreg_d    = 2'b00;
    regdst_d      = 2'b00;
    alusrcb_d     = 2'b00;
    aluop_d       = 2'b00;
    pcsource_d    = 2'b00;
    case (state_d)
      S_FETCH:  begin memread_d = 1'b1; alusrcb_d = 2'b01; end
      S_DECODE: alusrcb_d = 2'b11;
      S_MEMADR: begin alusrca_d = 1'b1; alusrcb_d = 2'b10; end
      S_MEMRD:  begin memread_d = 1'b1; iord_d = 1'b1; end
      S_MEMWB:  begin regwrite_d = 1'b1; memtoreg_d = 2'b01; end
      S_MEMWR:  begin memwrite_d = 1'b1; iord_d = 1'b1; end
      S_RTEXEC: begin alusrca_d = 1'b1; aluop_d = 2'b10; end
      S_RTWB:   begin regwrite_d = 1'b1; regdst_d = 2'b01; end
      S_BRANCH: begin
        alusrca_d     = 1'b1;
        aluop_d       = 2'b01;
        pcwritecond_d = 1'b1;
        pcsource_d    = 2'b01;
        branch_ne_d   = (opcode == OP_BNE);
      end
      S_JUMP:   begin pcwrite_d = 1'b1; pcsource_d = 2'b10; end
      S_JAL: begin
        pcwrite_d  = 1'b1;
        pcsource_d = 2'b10;
        regwrite_d = 1'b1;
        regdst_d   = 2'b10;
        memtoreg_d = 2'b10;
      end
      S_ADDIEX: begin alusrca_d = 1'b1; alusrcb_d = 2'b10; end
      S_ADDIWB: regwrite_d = 1'b1;
      S_HALT:   halted_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pcwrite_q   <= 1'b0;
      pcwritecond <= 1'b0;
      branch_ne   <= 1'b0;
      iord        <= 1'b0;
      memread     <= 1'b1;
      memwrite    <= 1'b0;
      regwrite    <= 1'b0;
      alusrca     <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      memtoreg    <= 2'b00;
      regdst      <= 2'b00;
      alusrcb     <= 2'b01;
      aluop       <= 2'b00;
      pcsource    <= 2'b00;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state_q     <= state_d;
      pcwrite_q   <= pcwrite_d;
      pcwritecond <= pcwritecond_d;
      branch_ne   <= branch_ne_d;
      iord        <= iord_d;
      memread     <= memread_d;
      memwrite    <= memwrite_d;
      regwrite    <= regwrite_d;
      alusrca     <= alusrca_d;
      halted      <= halted_d;
      illegal     <= illegal | decode_bad;
      memtoreg    <= memtoreg_d;
      regdst      <= regdst_d;
      alusrcb     <= alusrcb_d;
      aluop       <= aluop_d;
      pcsource    <= pcsource_d;
      if (state_q != S_HALT) cycle_count <= cycle_count + CNT_W'(1);
      if (state_d == S_FETCH && state_q != S_FETCH) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Fetch completes in the same cycle memory answers, so PC/IR loads follow mem_ready directly.
  assign irwrite = (state_q == S_FETCH) && mem_ready && !reset;
  assign pcwrite = pcwrite_q || irwrite;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction state paths and control
// vectors come from an opcode-level reference model, counters from instruction tallies.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite;
  logic [1:0]  memtoreg, regdst, alusrcb, aluop, pcsource;
  logic        regwrite, alusrca, halted, illegal;
  logic [3:0]  state;
  logic [31:0] cycle_count, instr_count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] m_cyc, m_ins;
  bit          m_ill;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .branch_ne(branch_ne), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsource(pcsource), .halted(halted), .illegal(illegal),
    .state(state), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  logic [20:0] ctrl;
  assign ctrl = {pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite,
                 memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource, halted, illegal};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-state control table: what each state drives onto the datapath.
  function automatic logic [20:0] exp_ctrl(input int st, input bit bne, input bit rdy, input bit ill);
    logic pcw, pcwc, bno, io, mr, mw, irw, rw, asa, hlt, il;
    logic [1:0] mtr, rd, asb, aop, psrc;
    {pcw, pcwc, bno, io, mr, mw, irw, rw, asa, hlt, il} = '0;
    {mtr, rd, asb, aop, psrc} = '0;
    case (st)
      0:  begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; mtr = 2'b01; end
      5:  begin mw = 1; io = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; bno = bne; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin pcw = 1; psrc = 2'b10; rw = 1; rd = 2'b10; mtr = 2'b10; end
      11: begin asa = 1; asb = 2'b10; end
      12: rw = 1;
      13: begin hlt = 1; il = ill; end
      default: ;
    endcase
    return {pcw, pcwc, bno, io, mr, mw, irw, mtr, rd, rw, asa, asb, aop, psrc, hlt, il};
  endfunction

  // One clock: drive mem_ready at the falling edge, check, then advance.
  task automatic step(input int st, input bit rdy, input bit bne);
    mem_ready = rdy;
    #1;
    chk("state", 64'(state), 64'(st));
    chk("ctrl", 64'(ctrl), 64'(exp_ctrl(st, bne, rdy, m_ill)));
    @(posedge clk);
    if (st != 13) m_cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cyc", 64'(cycle_count), 64'd0);
    chk("rst_ins", 64'(instr_count), 64'd0);
    chk("rst_strobes", 64'({pcwrite, irwrite, regwrite, memwrite, memread}), 64'b00001);
    chk("rst_flags", 64'({halted, illegal}), 64'b00);
    @(negedge clk);
    chk("rst_hold", 64'({state, pcwrite, irwrite, memread}), 64'({4'd0, 3'b001}));
    reset = 1'b0;
    m_cyc = '0;
    m_ins = '0;
    m_ill = 1'b0;
  endtask

  // Build the expected state path for one instruction from its opcode and wait counts.
  task automatic run_instr(input logic [31:0] w, input int wf, input int wm);
    int   sts[$];
    bit   rdys[$];
    bit   halt_here;
    logic [5:0] op;
    op = w[31:26];
    instr = w;
    halt_here = 1'b0;
    repeat (wf) begin sts.push_back(0); rdys.push_back(1'b0); end
    sts.push_back(0); rdys.push_back(1'b1);
    sts.push_back(1); rdys.push_back(1'($urandom));
    if (w == 32'h0) halt_here = 1'b1;
    else begin
      case (op)
        6'b100011: begin
          sts.push_back(2); rdys.push_back(1'($urandom));
          repeat (wm) begin sts.push_back(3); rdys.push_back(1'b0); end
          sts.push_back(3); rdys.push_back(1'b1);
          sts.push_back(4); rdys.push_back(1'($urandom));
        end
        6'b101011: begin
          sts.push_back(2); rdys.push_back(1'($urandom));
          repeat (wm) begin sts.push_back(5); rdys.push_back(1'b0); end
          sts.push_back(5); rdys.push_back(1'b1);
        end
        6'b000000: begin sts.push_back(6); rdys.push_back(1'($urandom)); sts.push_back(7); rdys.push_back(1'($urandom)); end
        6'b000100, 6'b000101: begin sts.push_back(8); rdys.push_back(1'($urandom)); end
        6'b000010: begin sts.push_back(9); rdys.push_back(1'($urandom)); end
        6'b000011: begin sts.push_back(10); rdys.push_back(1'($urandom)); end
        6'b001000: begin sts.push_back(11); rdys.push_back(1'($urandom)); sts.push_back(12); rdys.push_back(1'($urandom)); end
        default: begin halt_here = 1'b1; m_ill = 1'b1; end
      endcase
    end
    if (halt_here) repeat (3) begin sts.push_back(13); rdys.push_back(1'($urandom)); end
    foreach (sts[i]) step(sts[i], rdys[i], op == 6'b000101);
    if (!halt_here) m_ins++;
    #1;
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("instr_count", 64'(instr_count), 64'(m_ins));
    if (!halt_here) chk("back_to_fetch", 64'(state), 64'd0);
  endtask

  logic [5:0]  legal_ops [8];
  logic [31:0] w;

  initial begin
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b001000};
    reset = 1'b1;
    instr = '0;
    mem_ready = 1'b1;
    m_cyc = '0;
    m_ins = '0;
    m_ill = 1'b0;
    do_reset();

    run_instr(32'h8C08_0004, 0, 0);
    run_instr(32'h012A_4020, 3, 0);
    run_instr(32'h1509_FFFF, 0, 0);
    run_instr(32'h1109_0003, 1, 0);
    run_instr(32'h0C10_0004, 0, 0);
    run_instr(32'hAD09_0008, 0, 2);
    run_instr(32'h2108_0005, 0, 0);
    run_instr(32'h0810_0000, 2, 0);
    run_instr(32'h8C08_0010, 1, 3);

    for (int n = 0; n < 40; n++) begin
      w = {legal_ops[$urandom_range(0, 7)], 26'($urandom)};
      if (w == 32'h0) w = 32'h0000_0020;
      run_instr(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    run_instr(32'hFC00_0000, 1, 0);
    chk("illegal_halt", 64'({halted, illegal}), 64'b11);
    do_reset();
    run_instr(32'h8C08_0004, 0, 1);
    run_instr(32'h0000_0000, 0, 0);
    chk("zero_halt", 64'({halted, illegal}), 64'b10);
    do_reset();

    // Asynchronous reset in the middle of a store stall.
    instr = 32'hAD09_0008;
    step(0, 1'b1, 1'b0);
    step(1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    step(5, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("stall_memwrite", 64'({memwrite, iord, state}), 64'({2'b11, 4'd5}));
    #1 reset = 1'b1;
    #1;
    chk("async_state", 64'(state), 64'd0);
    chk("async_cnt", 64'({cycle_count, instr_count}), 64'd0);
    chk("async_memwrite", 64'({memwrite, memread}), 64'b01);
    @(posedge clk);
    #1;
    chk("rst_edge_memwrite", 64'({memwrite, state}), 64'({1'b0, 4'd0}));
    @(negedge clk);
    reset = 1'b0;
    m_cyc = '0;
    m_ins = '0;
    m_ill = 1'b0;
    run_instr(32'h0109_5022, 0, 0);
    run_instr(32'hAD09_0008, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
